// File: rtl/i2c_master_wr.sv
// Write-only I2C master: START, 7-bit address + R/W, ACK-gated data bytes from a
// valid/ready source, STOP. Every bus phase is built from four equal SCL quarters.
module i2c_master_wr #(
  parameter int DIV_QTR = 125,
  parameter bit RW_BIT  = 1'b0
) (
  input  logic       i_Clk,
  input  logic       reset,
  input  logic       i_Start,
  input  logic [6:0] i_Addr,
  input  logic       i_Tx_Valid,
  input  logic [7:0] i_Tx_Data,
  output logic       o_Tx_Ready,
  input  logic       i_Sda,
  output logic       o_Scl,
  output logic       o_Sda,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Nack
);

  localparam int            CW      = (DIV_QTR > 1) ? $clog2(DIV_QTR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_QTR - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d, done_q, done_d, nack_q, nack_d, rdy_q, rdy_d;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic          qtr_end, bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    rdy_d   = 1'b0;
    qtr_end = (cnt_q == CNT_MAX);
    bit_end = qtr_end && (q_q == 2'd3);

    if (state_q != IDLE) begin
      if (qtr_end) begin
        cnt_d = '0;
        q_d   = q_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d = START;
          cnt_d   = '0;
          q_d     = 2'd0;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
          shift_d = {i_Addr, RW_BIT};
        end
      end
      START: if (bit_end) state_d = ADDR;
      ADDR, DATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ACK_A : ACK_D;
        end
      end
      ACK_A, ACK_D: begin
        // The slave's answer is taken once, on the last clock of the SCL-high first half.
        if (qtr_end && (q_q == 2'd1)) ack_d = i_Sda;
        if (bit_end) begin
          bit_d = 3'd0;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (i_Tx_Valid) begin
            shift_d = i_Tx_Data;
            rdy_d   = 1'b1;
            state_d = DATA;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line levels follow the next state so the outputs stay registered yet aligned.
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      START: begin
        scl_d = (q_d == 2'd0) || (q_d == 2'd1);
        sda_d = (q_d == 2'd0);
      end
      ADDR, DATA: begin
        scl_d = (q_d == 2'd1) || (q_d == 2'd2);
        sda_d = shift_d[7];
      end
      ACK_A, ACK_D: scl_d = (q_d == 2'd1) || (q_d == 2'd2);
      STOP: begin
        scl_d = (q_d != 2'd0);
        sda_d = (q_d == 2'd2) || (q_d == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 2'd0;
      bit_q   <= 3'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      rdy_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      rdy_q   <= rdy_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    shift_q <= shift_d;
  end

  assign o_Scl      = scl_q;
  assign o_Sda      = sda_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Nack     = nack_q;
  assign o_Tx_Ready = rdy_q;

endmodule

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 Parameter DIV_QTR, default 125, SHALL set the number of i_Clk cycles per SCL quarter-period (125 at 50 MHz gives 100 kHz SCL); legal range 2..65535.
REQ-002 Parameter RW_BIT, default 0, SHALL set the R/W bit value appended to the address byte.
REQ-003 i_Clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_Start  input  1  transaction request; sampled only in IDLE.
REQ-006 i_Addr  input  7  slave address; captured on accepted i_Start.
REQ-007 i_Tx_Valid  input  1  a data byte is available on i_Tx_Data.
REQ-008 i_Tx_Data  input  8  data byte, MSB first on the bus.
REQ-009 o_Tx_Ready  output  1  one-cycle pulse; the byte on i_Tx_Data was consumed that cycle.
REQ-010 i_Sda  input  1  sampled SDA line, used for ACK detection.
REQ-011 o_Scl  output  1  SCL drive (1 = released/high).
REQ-012 o_Sda  output  1  SDA drive (1 = released/high).
REQ-013 o_Busy  output  1  high from accepted start until the cycle o_Done pulses.
REQ-014 o_Done  output  1  one-cycle pulse at end of STOP.
REQ-015 o_Nack  output  1  sticky NACK flag; cleared on the next accepted i_Start.

Function
REQ-016 A quarter counter SHALL count 0..DIV_QTR-1 and advance the quarter index q (0..3) on wrap; one bit-time SHALL equal 4*DIV_QTR clocks.
REQ-017 States SHALL be IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP; every non-IDLE state SHALL last whole bit-times.
REQ-018 In IDLE, o_Scl=1 and o_Sda=1; i_Start=1 SHALL transition to START on the next clock, with the quarter counter and q zeroed.
REQ-019 In START: q0 has SDA=1, SCL=1; q1 has SDA=0, SCL=1; q2 and q3 have SDA=0, SCL=0.
REQ-020 In a bit state (ADDR/DATA/ACK), SCL SHALL be 0 in q0 and q3 and 1 in q1 and q2; SDA SHALL change only at the start of q0.
REQ-021 ADDR SHALL send 8 bits: i_Addr[6:0] MSB first, then RW_BIT.
REQ-022 In ACK_A and ACK_D, o_Sda SHALL be 1 (released); i_Sda SHALL be sampled on the last clock of q1; 0 means ACK and 1 means NACK.
REQ-023 On NACK: set o_Nack and go to STOP, with no o_Tx_Ready pulse.
REQ-024 On ACK at the end of an ACK bit, if i_Tx_Valid=1, load i_Tx_Data into the shift register, pulse o_Tx_Ready, and go to DATA; otherwise go to STOP.
REQ-025 DATA SHALL shift 8 bits MSB first, then go to ACK_D.
REQ-026 In STOP: q0 has SDA=0, SCL=0; q1 has SDA=0, SCL=1; q2 and q3 have SDA=1, SCL=1; at the end of q3, pulse o_Done, drop o_Busy, and return to IDLE.
REQ-027 i_Start while not in IDLE SHALL be ignored; i_Tx_Valid SHALL be ignored except at ACK end.
REQ-028 Frame length for N data bytes SHALL be (11+9N)*4*DIV_QTR clocks from the accepted i_Start to the o_Done pulse; a NACK at the address gives 11*4*DIV_QTR clocks.
REQ-029 The bit counter SHALL be 3 bits wide and the quarter counter SHALL be $clog2(DIV_QTR) bits wide; neither SHALL wrap outside its own state.

Reset
REQ-030 While reset=0, all of the following SHALL hold: state=IDLE, o_Scl=1, o_Sda=1, o_Busy=0, o_Done=0, o_Nack=0, o_Tx_Ready=0, and all counters zero.
REQ-031 Reset asserted mid-frame SHALL release both lines immediately without generating a STOP.
REQ-032 After reset is released, the first accepted i_Start SHALL begin a clean START.

Verification (DIV_QTR=4)
REQ-033 Start with address 0x50, one byte 0xA5, slave ACKs, i_Tx_Valid dropped after the first o_Tx_Ready -> SDA bits 1010000 0 A 10100101 A, then STOP; o_Done occurs 320 clocks after start and o_Nack=0.
REQ-034 Address 0x3C with the slave NACK at ACK_A -> o_Nack=1, no o_Tx_Ready pulse, STOP follows, and o_Done occurs at 176 clocks.
REQ-035 Three bytes (0x01, 0x02, 0x03) all ACKed -> exactly three o_Tx_Ready pulses, each at an ACK end, and o_Done at 608 clocks.
REQ-036 i_Start pulsed during DATA -> no effect; the frame completes unchanged.
REQ-037 reset=0 asserted during DATA bit 4 -> o_Scl=1 and o_Sda=1 within the same cycle; after release, a new frame matches scenario REQ-033.
REQ-038 i_Sda is checked only at q1 end: a NACK glitch in q0 or q3 of an ACK bit -> still treated as ACK.
